ual_result_stage: RTL and testbench
===================================

# ual_result_stage

Registered output stage placed directly downstream of the 8-bit arithmetic unit of the UAL. Each cycle it captures the arithmetic unit's result, carry-out and overflow. It derives zero and negative flags, and presents result plus flags over a valid/ready handshake. A two-entry skid buffer sustains one result per cycle under backpressure, and a status register holds the flags of the last result delivered, for use by later condition logic.

## Interface
- DATA_W, 8, datapath width; must match the arithmetic unit width.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  arithmetic unit result valid this cycle.
- in_ready  output  1  stage can accept a result this cycle.
- au_out  input  DATA_W  sum/difference from the arithmetic unit.
- au_c  input  1  carry-out of the MSB (for subtraction, 1 = no borrow).
- au_o  input  1  signed overflow, carry into MSB xor carry out of MSB.
- add  input  1  operation tag: 1 = add, 0 = subtract; carried with the result.
- out_valid  output  1  res/flags valid.
- out_ready  input  1  consumer accepts this cycle.
- res  output  DATA_W  buffered result.
- flag_c, flag_o, flag_z, flag_n  output  1 each  flags of the presented result.
- res_add  output  1  operation tag of the presented result.
- stat_c, stat_o, stat_z, stat_n  output  1 each  flags of the last result handed off.

## Operation
- Input handshake: accept when in_valid and in_ready.
- Output handshake: hand off when out_valid and out_ready.
- Flag derivation at capture: Z = (au_out == 0); N = au_out[DATA_W-1]; C = au_c; O = au_o. Raw values are stored; no borrow inversion.
- Storage: main slot M drives the outputs; skid slot S holds one overflow entry. Each entry holds result, four flags and tag.
- State, encoded by occupancy: EMPTY (M and S empty), ONE (M full), TWO (M and S full).
- EMPTY: on accept, load M and go to ONE.
- ONE, accept without handoff: load S and go to TWO.
- ONE, handoff without accept: go to EMPTY.
- ONE, accept with handoff: reload M and stay in ONE.
- TWO: no accept possible. On handoff, move S into M and go to ONE.
- in_ready = not TWO, decoded from registered state. No combinational path from out_ready to in_ready.
- out_valid = not EMPTY.
- Order is strict FIFO; no entry is dropped or duplicated.
- Status register: on every handoff, stat_* load the flag_* values being handed off. Otherwise stat_* hold.

## Timing
- Latency: a result accepted in cycle t is presented with out_valid at t+1 if the stage was EMPTY, or the ONE-with-handoff case applied.
- Throughput: one result per cycle while out_ready stays high.
- Backpressure: with out_ready low, two results are absorbed, then in_ready falls in the cycle after the second accept.
- After the TWO-state handoff, in_ready rises in the next cycle.
- res, flags and tag are stable while out_valid is high and out_ready is low.
- Reset (rst_n low at an edge), including mid-transfer:
  - state becomes EMPTY, discarding buffered entries;
  - out_valid = 0 and in_ready = 1 from the next cycle;
  - res = 0, flag_* = 0, res_add = 0;
  - stat_z = 1, all other stat_* = 0.
- Inputs in the reset cycle are ignored.

## Structure
- Shared package ual_pkg holds:
  - localparam UAL_W = 8;
  - typedef struct packed ual_flags_t {c, o, z, n};
  - typedef struct packed ual_entry_t {res, flags, add};
  - enum ual_occ_t {EMPTY, ONE, TWO}.
- Sub-module ual_flag_gen is combinational: au_out, au_c, au_o -> ual_flags_t. It is reused by later logic-unit stages.
- Everything else, the two entry registers, state and status register, is flat in ual_result_stage.

## Test plan
- Add 0x7F + 0x01 (add=1, au_out=0x80, au_c=0, au_o=1), out_ready=1 -> next cycle res=0x80, C=0, O=1, Z=0, N=1, res_add=1; stat_* identical one cycle after handoff.
- Subtract 0x05 - 0x05 (add=0, au_out=0x00, au_c=1, au_o=0) -> res=0x00, C=1, O=0, Z=1, N=0.
- Hold out_ready=0 and drive results 0x11, 0x22, 0x33 on consecutive cycles -> 0x11 and 0x22 accepted, in_ready=0 while 0x33 is offered; release out_ready -> outputs 0x11, 0x22, 0x33 in order with no gaps once 0x33 is accepted.
- Stream 16 results with in_valid=1 and out_ready=1 -> 16 handoffs on consecutive cycles, in_ready never low.
- Assert reset while in TWO -> next cycle out_valid=0, in_ready=1, res=0, stat_z=1, other stat_*=0; buffered entries never appear.
- Toggle out_ready randomly (50%) over 200 random operations -> output sequence equals the accepted sequence, flags match the reference model, and res stays stable while stalled.

Source files
------------

// File: rtl/ual_pkg.sv
// Shared types for the UAL result/flag stages.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ual_pkg;

  // Datapath width of the arithmetic and logic units.
  localparam int UAL_W = 8;

  // Condition flags. Field order fixes the packed layout {c, o, z, n}.
  typedef struct packed {
    logic c;  // carry-out of MSB (raw; for subtract 1 = no borrow)
    logic o;  // signed overflow
    logic z;  // result is zero
    logic n;  // result MSB
  } ual_flags_t;

  // One buffered result: value, its flags and the add/subtract tag.
  typedef struct packed {
    logic [UAL_W-1:0] res;
    ual_flags_t       flags;
    logic             add;
  } ual_entry_t;

  // Occupancy of the main/skid pair.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } ual_occ_t;

  // Status register reset value: only Z set, as if a zero had been delivered.
  localparam ual_flags_t STAT_RST = '{c: 1'b0, o: 1'b0, z: 1'b1, n: 1'b0};

endpackage

// File: rtl/ual_flag_gen.sv
// Derives condition flags from an arithmetic result; shared with logic-unit stages.
// Latency: combinational, no state.
// Backpressure: none (pure function of its inputs).
//
// Ports:
//   au_out_i  result value
//   au_c_i    carry-out of the MSB, passed through unmodified
//   au_o_i    signed overflow, passed through unmodified
//   flags_o   packed as ual_flags_t {c, o, z, n}
module ual_flag_gen
  import ual_pkg::*;
(
  input  logic [UAL_W-1:0] au_out_i,
  input  logic             au_c_i,
  input  logic             au_o_i,
  output logic [3:0]       flags_o
);

  ual_flags_t flags;

  always_comb begin
    flags.c = au_c_i;
    flags.o = au_o_i;
    flags.z = (au_out_i == '0);
    flags.n = au_out_i[UAL_W-1];
  end

  assign flags_o = flags;

endmodule

// File: rtl/ual_result_stage.sv
// Registered result stage behind the UAL arithmetic unit: captures result,
// derives flags, and keeps a status copy of the flags last handed off.
// Latency: 1 cycle from accept to out_valid when the stage is empty or draining.
// Backpressure: 2-entry skid; in_ready is registered-state decoded, so it
// drops the cycle after the second unconsumed accept and never depends on out_ready.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid / in_ready        upstream handshake
//   au_out, au_c, au_o, add    arithmetic result, carry, overflow, op tag
//   out_valid / out_ready      downstream handshake
//   res, flag_c/o/z/n, res_add presented entry (main slot)
//   stat_c/o/z/n               flags of the most recent handoff
module ual_result_stage
  import ual_pkg::*;
#(
  parameter int DATA_W = UAL_W
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] au_out,
  input  logic              au_c,
  input  logic              au_o,
  input  logic              add,

  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] res,
  output logic              flag_c,
  output logic              flag_o,
  output logic              flag_z,
  output logic              flag_n,
  output logic              res_add,

  output logic              stat_c,
  output logic              stat_o,
  output logic              stat_z,
  output logic              stat_n
);

  ual_occ_t   occ_q, occ_d;
  ual_entry_t m_q, m_d;        // main slot, drives the outputs
  ual_entry_t s_q, s_d;        // skid slot, only valid in TWO
  ual_flags_t stat_q, stat_d;

  logic       accept;
  logic       handoff;
  logic [3:0] new_flags;
  ual_entry_t new_ent;

  ual_flag_gen u_flag_gen (
    .au_out_i (au_out),
    .au_c_i   (au_c),
    .au_o_i   (au_o),
    .flags_o  (new_flags)
  );

  assign new_ent = '{res: au_out, flags: ual_flags_t'(new_flags), add: add};

  assign in_ready  = (occ_q != TWO);
  assign out_valid = (occ_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign handoff   = out_valid & out_ready;

  always_comb begin
    occ_d  = occ_q;
    m_d    = m_q;
    s_d    = s_q;
    stat_d = stat_q;

    if (handoff) begin
      stat_d = m_q.flags;
    end

    case (occ_q)
      EMPTY: begin
        if (accept) begin
          m_d   = new_ent;
          occ_d = ONE;
        end
      end
      ONE: begin
        case ({accept, handoff})
          2'b10: begin
            s_d   = new_ent;
            occ_d = TWO;
          end
          2'b01: occ_d = EMPTY;
          2'b11: m_d   = new_ent;   // drain and refill in the same cycle
          default: ;
        endcase
      end
      TWO: begin
        // in_ready is low here, so only the drain side can move.
        if (handoff) begin
          m_d   = s_q;
          occ_d = ONE;
        end
      end
      default: occ_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q  <= EMPTY;
      m_q    <= '0;
      s_q    <= '0;
      stat_q <= STAT_RST;
    end else begin
      occ_q  <= occ_d;
      m_q    <= m_d;
      s_q    <= s_d;
      stat_q <= stat_d;
    end
  end

  assign res     = m_q.res;
  assign flag_c  = m_q.flags.c;
  assign flag_o  = m_q.flags.o;
  assign flag_z  = m_q.flags.z;
  assign flag_n  = m_q.flags.n;
  assign res_add = m_q.add;

  assign stat_c  = stat_q.c;
  assign stat_o  = stat_q.o;
  assign stat_z  = stat_q.z;
  assign stat_n  = stat_q.n;

endmodule

// File: tb/tb_ual_result_stage.sv
// Scoreboard bench for ual_result_stage: the driver pushes expected entries on
// accept, and an independent negedge monitor pops and compares on each handoff.
module tb_ual_result_stage;
  import ual_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [7:0] au_out;
  logic       au_c, au_o, add;
  logic       out_valid, out_ready;
  logic [7:0] res;
  logic       flag_c, flag_o, flag_z, flag_n, res_add;
  logic       stat_c, stat_o, stat_z, stat_n;

  always #5 clk = ~clk;

  ual_result_stage #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .au_out(au_out), .au_c(au_c), .au_o(au_o), .add(add),
    .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .flag_c(flag_c), .flag_o(flag_o), .flag_z(flag_z), .flag_n(flag_n),
    .res_add(res_add),
    .stat_c(stat_c), .stat_o(stat_o), .stat_z(stat_z), .stat_n(stat_n)
  );

  int         n_chk = 0;
  int         n_fail = 0;
  int         cyc = 0;
  ual_entry_t sb[$];
  logic [3:0] exp_stat = 4'b0010;
  int         ho_cnt = 0;
  int         gaps = 0;
  bit         prev_ho_vld = 0;
  int         prev_ho_cyc = 0;
  int         stall_cycles = 0;
  bit         stall_q = 0;
  logic [12:0] held = '0;
  bit         rnd_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [12:0] presented();
    return {res, flag_c, flag_o, flag_z, flag_n, res_add};
  endfunction

  // Monitor: signals sampled at negedge are exactly what the next posedge sees.
  always @(negedge clk) begin
    ual_entry_t e;
    if (rst_n) begin
      check("stat", 32'({stat_c, stat_o, stat_z, stat_n}), 32'(exp_stat));
      if (stall_q && out_valid)
        check("stall_stable", 32'(presented()), 32'(held));
      stall_q = out_valid && !out_ready;
      held    = presented();
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got res 0x%0h, expected no output", res);
        end else begin
          e = sb.pop_front();
          check("output", 32'(presented()), 32'(e));
          exp_stat = e.flags;
        end
        ho_cnt++;
        if (prev_ho_vld && cyc != prev_ho_cyc + 1) gaps++;
        prev_ho_vld = 1;
        prev_ho_cyc = cyc;
      end
    end else begin
      stall_q = 0;
    end
  end

  // Offers one result, waits (bounded) for acceptance, records the expectation.
  task automatic send(input logic [7:0] d, input logic c, input logic o, input logic a,
                      input logic z, input logic n);
    ual_entry_t e;
    int w = 0;
    au_out = d; au_c = c; au_o = o; add = a; in_valid = 1'b1;
    while (!in_ready) begin
      stall_cycles++;
      @(posedge clk); #1;
      w++;
      if (w > 1000) begin
        n_chk++;
        n_fail++;
        $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 1000 cycles");
        in_valid = 1'b0;
        return;
      end
    end
    e.res = d; e.flags.c = c; e.flags.o = o; e.flags.z = z; e.flags.n = n; e.add = a;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [7:0] d, input logic c, input logic o, input logic a);
    send(d, c, o, a, (d == 8'h00), d[7]);
  endtask

  task automatic drain(input string name);
    int w = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int ho0;
    logic [7:0] d;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    au_out = '0; au_c = 1'b0; au_o = 1'b0; add = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_presented", 32'(presented()), 32'd0);
    check("rst_stat", 32'({stat_c, stat_o, stat_z, stat_n}), 32'b0010);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 0x7F + 0x01 -> 0x80: C=0 O=1 Z=0 N=1
    out_ready = 1'b1;
    send(8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_presented", 32'(presented()), 32'({8'h80, 4'b0101, 1'b1}));
    @(posedge clk); #1;
    check("t1_stat", 32'({stat_c, stat_o, stat_z, stat_n}), 32'b0101);

    // 0x05 - 0x05 -> 0x00: C=1 O=0 Z=1 N=0
    send(8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t2_presented", 32'(presented()), 32'({8'h00, 4'b1010, 1'b0}));
    @(posedge clk); #1;
    check("t2_stat", 32'({stat_c, stat_o, stat_z, stat_n}), 32'b1010);

    // Backpressure: two absorbed, third blocked until release.
    out_ready = 1'b0;
    ho0 = ho_cnt;
    send(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    fork
      send(8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      begin
        check("t3_in_ready_low", 32'(in_ready), 32'd0);
        check("t3_hold_res", 32'(res), 32'h11);
        @(posedge clk); #1;
        check("t3_still_blocked", 32'(in_ready), 32'd0);
        gaps = 0; prev_ho_vld = 0;
        out_ready = 1'b1;
      end
    join
    drain("t3_drain");
    check("t3_handoffs", 32'(ho_cnt - ho0), 32'd3);
    check("t3_gaps", 32'(gaps), 32'd0);

    // Full-rate streaming.
    out_ready = 1'b1;
    stall_cycles = 0; gaps = 0; prev_ho_vld = 0; ho0 = ho_cnt;
    for (int i = 0; i < 16; i++) begin
      d = 8'(i * 16 + i);
      send_model(d, i[0], i[1], i[2]);
    end
    drain("t4_drain");
    check("t4_handoffs", 32'(ho_cnt - ho0), 32'd16);
    check("t4_in_ready_stalls", 32'(stall_cycles), 32'd0);
    check("t4_gaps", 32'(gaps), 32'd0);

    // Reset while TWO: buffered entries and the reset-cycle input are discarded.
    out_ready = 1'b0;
    send(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    send(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t5_in_two", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    in_valid = 1'b1; au_out = 8'hFF; au_c = 1'b1; au_o = 1'b1; add = 1'b1;
    sb.delete();
    exp_stat = 4'b0010;
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    check("t5_presented", 32'(presented()), 32'd0);
    check("t5_stat", 32'({stat_c, stat_o, stat_z, stat_n}), 32'b0010);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t5_no_ghost", 32'(out_valid), 32'd0);

    // Random traffic with random backpressure.
    ho0 = ho_cnt;
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send_model(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    drain("t6_drain");
    check("t6_handoffs", 32'(ho_cnt - ho0), 32'd200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
